// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with round-robin
// fairness, a bounded data lock and registered one-cycle responses.
// Optional: define MEM_ARB_WRITE_GUARD_EN to reject writes below DYN_BASE.
module mem_arbiter #(
    parameter int unsigned            ADDR_W   = 16,
    parameter int unsigned            DATA_W   = 32,
    parameter logic [ADDR_W-1:0]      DYN_BASE = 16'h8000,
    parameter int unsigned            LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_req_ready,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_lock,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {GrantFetch, GrantData} grant_e;

    localparam logic [3:0] LockLimit = 4'(LOCK_MAX);

    grant_e     last_grant, last_grant_nxt;
    logic [3:0] lock_cnt, lock_cnt_nxt;
    logic       lock_active;
    logic       grant_f, grant_d;
    logic       write_blocked;

`ifdef MEM_ARB_WRITE_GUARD_EN
    assign write_blocked = d_req_we && (d_req_addr < DYN_BASE);
`else
    assign write_blocked = 1'b0;
`endif

    // Grants are gated by rst_n so nothing is accepted or written while in reset.
    always_comb begin
        lock_active = d_lock && d_req_valid && (last_grant == GrantData) &&
                      (lock_cnt < LockLimit);
        grant_d     = rst_n && d_req_valid &&
                      (!f_req_valid || (last_grant == GrantFetch) || lock_active);
        grant_f     = rst_n && f_req_valid && !grant_d;
    end

    assign f_req_ready = grant_f;
    assign d_req_ready = grant_d;
    assign mem_we      = grant_d && d_req_we && !write_blocked;
    assign mem_wdata   = d_req_wdata;

    always_comb begin
        mem_addr = '0;
        if (grant_d) begin
            mem_addr = d_req_addr;
        end else if (grant_f) begin
            mem_addr = f_req_addr;
        end
    end

    always_comb begin
        last_grant_nxt = last_grant;
        lock_cnt_nxt   = lock_cnt;
        if (grant_d) begin
            last_grant_nxt = GrantData;
        end else if (grant_f) begin
            last_grant_nxt = GrantFetch;
        end
        // Only grants won through the lock against a waiting fetch use up the budget.
        if (!d_lock || grant_f) begin
            lock_cnt_nxt = '0;
        end else if (grant_d && f_req_valid && lock_active) begin
            lock_cnt_nxt = lock_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GrantFetch;
            lock_cnt   <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            lock_cnt   <= lock_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rsp_valid <= 1'b0;
            f_rsp_data  <= '0;
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else begin
            f_rsp_valid <= grant_f;
            d_rsp_valid <= grant_d;
            d_rsp_err   <= grant_d && write_blocked;
            if (grant_f) begin
                f_rsp_data <= mem_rdata;
            end
            if (grant_d) begin
                d_rsp_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level reference model predicts grants and
// responses, a negedge monitor pops and compares the response pulses.
module tb_mem_arbiter;

    localparam int unsigned   ADDR_W   = 16;
    localparam int unsigned   DATA_W   = 32;
    localparam logic [15:0]   DYN_BASE = 16'h8000;
    localparam int            LOCK_MAX = 4;
`ifdef MEM_ARB_WRITE_GUARD_EN
    localparam bit GuardOn = 1'b1;
`else
    localparam bit GuardOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req_valid = 1'b0;
    logic [15:0] f_req_addr = '0;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_data;
    logic        d_req_valid = 1'b0;
    logic [15:0] d_req_addr = '0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_wdata = '0;
    logic        d_lock = 1'b0;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        d_rsp_err;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DYN_BASE(DYN_BASE),
        .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req_valid(f_req_valid),
        .f_req_addr (f_req_addr),
        .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid),
        .f_rsp_data (f_rsp_data),
        .d_req_valid(d_req_valid),
        .d_req_addr (d_req_addr),
        .d_req_we   (d_req_we),
        .d_req_wdata(d_req_wdata),
        .d_lock     (d_lock),
        .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid),
        .d_rsp_data (d_rsp_data),
        .d_rsp_err  (d_rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, posedge write.
    logic [31:0] mem    [0:65535];
    logic [31:0] shadow [0:65535];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    function automatic logic [31:0] init_word(input int i);
        return {16'(i) ^ 16'hC3A5, 16'(i)};
    endfunction

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t f_q[$];
    exp_t d_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: who was granted last, locked grants used so far.
    bit m_last_data = 1'b0;
    int m_locks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic exp_fv, exp_dv;
    exp_t ef, ed;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_fv = (f_q.size() > 0) && (f_q[0].cyc == cyc - 1);
            if (f_rsp_valid || exp_fv) begin
                check("f_rsp_valid", f_rsp_valid, exp_fv);
                if (exp_fv) begin
                    ef = f_q.pop_front();
                    if (f_rsp_valid) check("f_rsp_data", f_rsp_data, ef.data);
                end
            end
            exp_dv = (d_q.size() > 0) && (d_q[0].cyc == cyc - 1);
            if (d_rsp_valid || exp_dv) begin
                check("d_rsp_valid", d_rsp_valid, exp_dv);
                if (exp_dv) begin
                    ed = d_q.pop_front();
                    if (d_rsp_valid) begin
                        check("d_rsp_data", d_rsp_data, ed.data);
                        check("d_rsp_err", d_rsp_err, ed.err);
                    end
                end
            end
        end
    end

    // One cycle: drive a request pair, predict the outcome from the rules, compare.
    task automatic step(input logic fv, input logic [15:0] fa, input logic dv,
                        input logic [15:0] da, input logic dwe, input logic [31:0] dwd,
                        input logic dlk, output logic gf, output logic gd);
        logic        locked, blk, exp_we;
        logic [15:0] exp_addr;
        @(posedge clk);
        #1;
        f_req_valid = fv;  f_req_addr = fa;
        d_req_valid = dv;  d_req_addr = da;  d_req_we = dwe;  d_req_wdata = dwd;
        d_lock = dlk;
        #1;
        locked = fv && dv && m_last_data && dlk && (m_locks < LOCK_MAX);
        gf = 1'b0;
        gd = 1'b0;
        if (dv && !fv) gd = 1'b1;
        else if (fv && !dv) gf = 1'b1;
        else if (fv && dv) begin
            if (!m_last_data || locked) gd = 1'b1;
            else gf = 1'b1;
        end
        blk      = GuardOn && dwe && (da < DYN_BASE);
        exp_we   = gd && dwe && !blk;
        exp_addr = gd ? da : (gf ? fa : 16'h0000);
        check("f_req_ready", f_req_ready, gf);
        check("d_req_ready", d_req_ready, gd);
        check("mem_we", mem_we, exp_we);
        check("mem_addr", mem_addr, exp_addr);
        if (exp_we) check("mem_wdata", mem_wdata, dwd);
        if (gf) f_q.push_back('{cyc: cyc, data: shadow[fa], err: 1'b0});
        if (gd) d_q.push_back('{cyc: cyc, data: shadow[da], err: blk});
        if (exp_we) shadow[da] = dwd;
        if (gf) m_last_data = 1'b0;
        if (gd) m_last_data = 1'b1;
        if (!dlk || gf) m_locks = 0;
        else if (locked) m_locks++;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 16'(16'h0000 + $urandom_range(0, 15));
            1:       return 16'(16'h8000 + $urandom_range(0, 15));
            default: return 16'(16'h7FF8 + $urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        logic        gf, gd;
        logic [5:0]  hist;
        logic        pf_v, pd_v, pd_we, pd_lk;
        logic [15:0] pf_a, pd_a;
        logic [31:0] pd_wd;

        for (int i = 0; i < 65536; i++) begin
            mem[i]    = init_word(i);
            shadow[i] = init_word(i);
        end

        // Reset: requests present, nothing may be accepted or written.
        f_req_valid = 1'b1;  f_req_addr = 16'h0010;
        d_req_valid = 1'b1;  d_req_addr = 16'h8001;  d_req_we = 1'b1;  d_req_wdata = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_f_req_ready", f_req_ready, 1'b0);
        check("rst_d_req_ready", d_req_ready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_f_rsp_valid", f_rsp_valid, 1'b0);
        check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        check("rst_f_rsp_data", f_rsp_data, 32'h0);
        check("rst_d_rsp_data", d_rsp_data, 32'h0);
        check("rst_d_rsp_err", d_rsp_err, 1'b0);
        f_req_valid = 1'b0;  d_req_valid = 1'b0;  d_req_we = 1'b0;
        rst_n = 1'b1;

        // Fetch only, consecutive addresses.
        for (int i = 0; i < 3; i++) step(1, 16'(16'h0010 + i), 0, 0, 0, 0, 0, gf, gd);

        // Both valid, no lock: strict alternation starting with data.
        hist = '0;
        for (int i = 0; i < 6; i++) begin
            step(1, 16'h0040, 1, 16'h8020, 0, 0, 0, gf, gd);
            hist = {hist[4:0], gd};
        end
        check("alternate_grants", hist, 6'b101010);

        // Write then immediate read-back in the dynamic region.
        step(0, 0, 1, 16'h8004, 1, 32'hDEADBEEF, 0, gf, gd);
        step(0, 0, 1, 16'h8004, 0, 0, 0, gf, gd);

        // Write below DYN_BASE, then reread.
        step(0, 0, 1, 16'h0004, 1, 32'h0000_1234, 0, gf, gd);
        step(0, 0, 1, 16'h0004, 0, 0, 0, gf, gd);
        check("guard_mem_contents", mem[16'h0004], GuardOn ? init_word(4) : 32'h0000_1234);

        // Lock: initial data grant plus LOCK_MAX locked grants, then fetch.
        step(1, 16'h0020, 0, 0, 0, 0, 0, gf, gd);
        hist = '0;
        for (int i = 0; i < 6; i++) begin
            step(1, 16'h0030, 1, 16'h8010, 0, 0, 1, gf, gd);
            hist = {hist[4:0], gd};
        end
        check("lock_grants", hist, 6'b111110);

        // Reset mid-operation while a data write is granted.
        step(0, 0, 1, 16'h8011, 0, 0, 0, gf, gd);
        step(0, 0, 0, 0, 0, 0, 0, gf, gd);
        @(posedge clk);
        #1;
        d_req_valid = 1'b1;  d_req_addr = 16'h8003;  d_req_we = 1'b1;
        d_req_wdata = 32'hCAFE_F00D;  d_lock = 1'b0;
        #1;
        check("pre_rst_d_req_ready", d_req_ready, 1'b1);
        check("pre_rst_mem_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("in_rst_mem_we", mem_we, 1'b0);
        check("in_rst_d_req_ready", d_req_ready, 1'b0);
        @(posedge clk);
        #1;
        check("in_rst_d_rsp_valid", d_rsp_valid, 1'b0);
        d_req_valid = 1'b0;  d_req_we = 1'b0;
        rst_n = 1'b1;
        f_q.delete();
        d_q.delete();
        m_last_data = 1'b0;
        m_locks = 0;
        check("rst_mem_unchanged", mem[16'h8003], init_word(16'h8003));
        step(1, 16'h0050, 1, 16'h8005, 0, 0, 0, gf, gd);
        check("post_rst_data_wins", gd, 1'b1);

        // Randomized traffic; a refused request is held stable until accepted.
        pf_v = 0;  pf_a = 0;
        pd_v = 0;  pd_a = 0;  pd_we = 0;  pd_wd = 0;  pd_lk = 0;
        gf = 1;  gd = 1;
        for (int n = 0; n < 3000; n++) begin
            if (!pf_v || gf) begin
                pf_v = ($urandom_range(0, 3) != 0);
                pf_a = rand_addr();
            end
            if (!pd_v || gd) begin
                pd_v  = ($urandom_range(0, 3) != 0);
                pd_a  = rand_addr();
                pd_we = $urandom_range(0, 1) == 1;
                pd_wd = $urandom;
                pd_lk = ($urandom_range(0, 2) != 0);
            end
            step(pf_v, pf_a, pd_v, pd_a, pd_we, pd_wd, pd_lk, gf, gd);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, gf, gd);
        @(negedge clk);
        check("f_q_drained", f_q.size(), 0);
        check("d_q_drained", d_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
